// File: rtl/fb_write_scheduler.sv
// Character frame-buffer write scheduler.
// Shares one single-port character buffer between a display reader, which has
// absolute priority while vga_busy is high, host character writes, and a
// full-screen clear sweep. A pending clear always wins over a host write.
//
// Ports:
//   master_clk, reset          clock, asynchronous active-high reset
//   wr_req/wr_col/wr_row/wr_char  host write request (level) and payload
//   wr_ack, wr_err             one-cycle accept pulse, error flag with the ack
//   clr_req                    one-cycle clear-screen request
//   clr_busy, clr_done         sweep in progress, one-cycle end-of-sweep pulse
//   vga_busy, vga_addr         reader owns the buffer port, reader address
//   fb_addr, fb_we, fb_wdata   buffer port
module fb_write_scheduler #(
   parameter int unsigned COLS  = 40,
   parameter int unsigned ROWS  = 15,
   parameter logic [7:0]  BLANK = 8'h20
) (
   input  logic       master_clk,
   input  logic       reset,
   input  logic       wr_req,
   input  logic [7:0] wr_col,
   input  logic [7:0] wr_row,
   input  logic [7:0] wr_char,
   output logic       wr_ack,
   output logic       wr_err,
   input  logic       clr_req,
   output logic       clr_busy,
   output logic       clr_done,
   input  logic       vga_busy,
   input  logic [9:0] vga_addr,
   output logic [9:0] fb_addr,
   output logic       fb_we,
   output logic [7:0] fb_wdata
);

   localparam int unsigned ADDR_W    = 10;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned LAST_ADDR = COLS * ROWS - 1;

   typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

   state_t              state_q, state_d;
   logic                pend_q, pend_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [7:0]          col_q, col_d;
   logic [7:0]          row_q, row_d;
   logic [DATA_W-1:0]   char_q, char_d;
   logic                err_q, err_d;
   logic [ADDR_W-1:0]   wr_addr;
   logic [ADDR_W-1:0]   host_addr;

   // Linear character address of the latched host write
   assign host_addr = ADDR_W'(32'(row_q) * COLS + 32'(col_q));

   // State and latched request registers
   always_ff @(posedge master_clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pend_q  <= 1'b0;
         cnt_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
         char_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         col_q   <= col_d;
         row_q   <= row_d;
         char_q  <= char_d;
         err_q   <= err_d;
      end
   end

   // Next-state and buffer-port control
   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q | clr_req;
      cnt_d    = cnt_q;
      col_d    = col_q;
      row_d    = row_q;
      char_d   = char_q;
      err_d    = err_q;
      wr_ack   = 1'b0;
      wr_err   = 1'b0;
      clr_done = 1'b0;
      fb_we    = 1'b0;
      fb_wdata = '0;
      wr_addr  = '0;

      case (state_q)
         IDLE: begin
            // A clear request in the same cycle is consumed by this entry
            if (pend_q || clr_req) begin
               state_d = CLEAR;
               pend_d  = 1'b0;
               cnt_d   = '0;
            end else if (wr_req) begin
               state_d = WRITE;
               col_d   = wr_col;
               row_d   = wr_row;
               char_d  = wr_char;
               err_d   = (32'(wr_col) >= COLS) || (32'(wr_row) >= ROWS);
            end
         end
         WRITE: begin
            // Out-of-range requests are acked with error, never written
            if (err_q) begin
               wr_ack  = 1'b1;
               wr_err  = 1'b1;
               state_d = IDLE;
            end else if (!vga_busy) begin
               fb_we    = 1'b1;
               fb_wdata = char_q;
               wr_addr  = host_addr;
               wr_ack   = 1'b1;
               state_d  = IDLE;
            end
         end
         CLEAR: begin
            if (!vga_busy) begin
               fb_we    = 1'b1;
               fb_wdata = BLANK;
               wr_addr  = cnt_q;
               if (cnt_q == ADDR_W'(LAST_ADDR)) begin
                  clr_done = 1'b1;
                  cnt_d    = '0;
                  state_d  = IDLE;
               end else begin
                  cnt_d = cnt_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Reader owns the address bus whenever it is busy
   assign fb_addr  = vga_busy ? vga_addr : wr_addr;
   assign clr_busy = (state_q == CLEAR);

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Self-checking bench for fb_write_scheduler: expected buffer writes and acks
// are queued when stimulus is issued and popped when the DUT produces them.
module tb_fb_write_scheduler;

   logic       master_clk;
   logic       reset;
   logic       wr_req;
   logic [7:0] wr_col;
   logic [7:0] wr_row;
   logic [7:0] wr_char;
   logic       wr_ack;
   logic       wr_err;
   logic       clr_req;
   logic       clr_busy;
   logic       clr_done;
   logic       vga_busy;
   logic [9:0] vga_addr;
   logic [9:0] fb_addr;
   logic       fb_we;
   logic [7:0] fb_wdata;

   fb_write_scheduler dut (
      .master_clk (master_clk),
      .reset      (reset),
      .wr_req     (wr_req),
      .wr_col     (wr_col),
      .wr_row     (wr_row),
      .wr_char    (wr_char),
      .wr_ack     (wr_ack),
      .wr_err     (wr_err),
      .clr_req    (clr_req),
      .clr_busy   (clr_busy),
      .clr_done   (clr_done),
      .vga_busy   (vga_busy),
      .vga_addr   (vga_addr),
      .fb_addr    (fb_addr),
      .fb_we      (fb_we),
      .fb_wdata   (fb_wdata)
   );

   initial begin
      master_clk = 1'b0;
      forever #5 master_clk = ~master_clk;
   end

   int         n_cmp = 0;
   int         n_mis = 0;
   logic [17:0] wq[$];   // {addr, data} of expected buffer writes, in order
   logic        aq[$];   // expected wr_err for each expected ack
   logic        got_ack, got_done, got_busy;
   logic [9:0]  done_addr;
   int          n, dones;
   logic        acked;

   task automatic chk(input string tag, input int unsigned obs, input int unsigned expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // One clock cycle: check outputs on the falling edge, return 1 ns after rise
   task automatic step();
      logic [17:0] e;
      logic        ee;
      @(negedge master_clk);
      got_ack  = wr_ack;
      got_done = clr_done;
      got_busy = clr_busy;
      if (clr_done) done_addr = fb_addr;
      if (vga_busy) begin
         chk("busy_addr", fb_addr, vga_addr);
         chk("busy_we", 32'(fb_we), 0);
      end
      if (fb_we) begin
         if (wq.size() == 0) chk("spurious_we", 32'(fb_we), 0);
         else begin
            e = wq.pop_front();
            chk("wr_addr", fb_addr, 32'(e[17:8]));
            chk("wr_data", fb_wdata, 32'(e[7:0]));
         end
      end else if (!vga_busy) begin
         chk("idle_addr", fb_addr, 0);
      end
      if (wr_ack) begin
         if (aq.size() == 0) chk("spurious_ack", 32'(wr_ack), 0);
         else begin
            ee = aq.pop_front();
            chk("wr_err", 32'(wr_err), 32'(ee));
         end
      end else begin
         chk("err_no_ack", 32'(wr_err), 0);
      end
      @(posedge master_clk);
      #1;
   endtask

   // Host write with vga_busy low; checks request-to-ack latency in cycles
   task automatic host_write(input int col, input int row, input logic [7:0] ch,
                             input int exp_lat);
      logic err;
      int   k;
      err = (col >= 40) || (row >= 15);
      aq.push_back(err);
      if (!err) wq.push_back({10'(row * 40 + col), ch});
      wr_col  = 8'(col);
      wr_row  = 8'(row);
      wr_char = ch;
      wr_req  = 1'b1;
      k = 0;
      got_ack = 1'b0;
      while (!got_ack && k < 200) begin
         step();
         k++;
      end
      wr_req = 1'b0;
      chk("ack_latency", k, exp_lat);
   endtask

   // Full clear sweep with the reader idle
   task automatic full_clear();
      int k;
      clr_req = 1'b1;
      for (int i = 0; i < 600; i++) wq.push_back({10'(i), 8'h20});
      step();
      chk("clr_busy_pre", 32'(got_busy), 0);
      clr_req  = 1'b0;
      k        = 0;
      got_done = 1'b0;
      while (!got_done && k < 700) begin
         step();
         k++;
         chk("clr_busy_in", 32'(got_busy), 1);
      end
      chk("clr_cycles", k, 600);
      chk("done_addr", done_addr, 599);
      step();
      chk("clr_busy_post", 32'(got_busy), 0);
      chk("clr_sb_empty", wq.size(), 0);
   endtask

   initial begin
      reset    = 1'b1;
      wr_req   = 1'b0;
      wr_col   = '0;
      wr_row   = '0;
      wr_char  = '0;
      clr_req  = 1'b0;
      vga_busy = 1'b0;
      vga_addr = '0;

      // Reset state
      #2;
      chk("rst_we", 32'(fb_we), 0);
      chk("rst_ack", 32'(wr_ack), 0);
      chk("rst_clr_busy", 32'(clr_busy), 0);
      chk("rst_clr_done", 32'(clr_done), 0);
      chk("rst_wdata", fb_wdata, 0);
      chk("rst_addr", fb_addr, 0);
      step();
      step();
      reset = 1'b0;
      step();

      // Basic writes, boundaries and out-of-range requests
      host_write(3, 2, 8'h41, 2);
      host_write(40, 0, 8'h55, 2);
      host_write(0, 15, 8'h66, 2);
      host_write(39, 14, 8'h7A, 2);
      host_write(0, 0, 8'h30, 2);
      step();

      // Write stalled by the reader for 10 cycles
      aq.push_back(1'b0);
      wq.push_back({10'(1 * 40 + 10), 8'h7E});
      wr_col   = 8'd10;
      wr_row   = 8'd1;
      wr_char  = 8'h7E;
      wr_req   = 1'b1;
      vga_busy = 1'b1;
      vga_addr = 10'd123;
      for (int i = 0; i < 11; i++) begin
         step();
         chk("stall_no_ack", 32'(got_ack), 0);
      end
      vga_busy = 1'b0;
      step();
      chk("stall_ack", 32'(got_ack), 1);
      wr_req = 1'b0;
      step();

      // Full clear
      full_clear();

      // Clear and write together, second clear mid-sweep, random reader stalls
      for (int i = 0; i < 1200; i++) wq.push_back({10'(i % 600), 8'h20});
      wq.push_back({10'(7 * 40 + 5), 8'h5A});
      aq.push_back(1'b0);
      wr_col  = 8'd5;
      wr_row  = 8'd7;
      wr_char = 8'h5A;
      wr_req  = 1'b1;
      dones   = 0;
      acked   = 1'b0;
      for (int i = 0; i < 4000 && !acked; i++) begin
         clr_req  = (i == 0) || (i == 100);
         vga_busy = ($urandom_range(0, 3) == 0);
         vga_addr = 10'($urandom_range(0, 1023));
         step();
         if (got_done) dones++;
         if (got_ack) acked = 1'b1;
      end
      clr_req  = 1'b0;
      wr_req   = 1'b0;
      vga_busy = 1'b0;
      chk("combo_acked", 32'(acked), 1);
      chk("combo_dones", dones, 2);
      chk("combo_sb_empty", wq.size(), 0);
      step();

      // Reset in the middle of a sweep, just after address 300 was written
      clr_req = 1'b1;
      for (int i = 0; i <= 300; i++) wq.push_back({10'(i), 8'h20});
      step();
      clr_req = 1'b0;
      n = 0;
      while (wq.size() != 0 && n < 400) begin
         step();
         n++;
      end
      chk("mid_reached_300", wq.size(), 0);
      reset = 1'b1;
      #1;
      chk("midrst_we", 32'(fb_we), 0);
      chk("midrst_addr", fb_addr, 0);
      chk("midrst_busy", 32'(clr_busy), 0);
      chk("midrst_done", 32'(clr_done), 0);
      step();
      reset = 1'b0;
      step();
      chk("post_rst_done", 32'(got_done), 0);
      chk("post_rst_busy", 32'(got_busy), 0);
      full_clear();

      chk("final_sb", wq.size() + aq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/fb_write_scheduler.md
FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

Interface
REQ-001 SHALL have parameters: COLS, default 40, text columns; ROWS, default 15, text rows; BLANK, default 8'h20, clear fill character.
REQ-002 SHALL have port master_clk, input, 1, single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have ports wr_req in 1 (host write request, level), wr_col in 8, wr_row in 8, wr_char in 8, wr_ack out 1 (one-cycle pulse), wr_err out 1 (one-cycle pulse, with wr_ack).
REQ-005 SHALL have ports clr_req in 1 (one-cycle pulse, clear screen), clr_busy out 1, clr_done out 1 (one-cycle pulse).
REQ-006 SHALL have ports vga_busy in 1 (display reader owns buffer port), vga_addr in 10 (reader address).
REQ-007 SHALL have ports fb_addr out 10, fb_we out 1, fb_wdata out 8 (single-port character buffer).

Function
REQ-008 SHALL implement FSM states IDLE, WRITE, CLEAR.
REQ-009 SHALL hold a clr_pending flag: set on clr_req in any state; cleared on entry to CLEAR.
REQ-010 IDLE: clr_pending=1 -> CLEAR with sweep counter 0; else wr_req=1 -> WRITE, latching col/row/char; else stay. Clear beats host write.
REQ-011 On IDLE->WRITE with wr_col>=COLS or wr_row>=ROWS: latch an error flag; in WRITE, assert wr_ack and wr_err for one cycle, no fb_we, return to IDLE.
REQ-012 WRITE (valid): in the first cycle with vga_busy=0, assert fb_we=1 and wr_ack=1 (combinational, same cycle), then IDLE; while vga_busy=1, wait with no ack.
REQ-013 Write address SHALL be row*COLS+col, computed in 10 bits ((row<<5)+(row<<3)+col for COLS=40); max 599.
REQ-014 CLEAR: each cycle with vga_busy=0 assert fb_we=1, fb_wdata=BLANK, fb_addr=counter, increment counter; vga_busy=1 stalls counter with no write.
REQ-015 CLEAR SHALL end after writing address COLS*ROWS-1 (599): clr_done pulse that cycle, next state IDLE; clr_busy=1 exactly while in CLEAR.
REQ-016 clr_req during CLEAR SHALL not restart the sweep; it sets clr_pending so one further full sweep follows.
REQ-017 wr_req held during CLEAR SHALL get no wr_ack until CLEAR exits and it is accepted from IDLE.
REQ-018 fb_addr SHALL equal vga_addr whenever vga_busy=1; fb_we SHALL never be 1 while vga_busy=1.
REQ-019 When vga_busy=0 and no write is issued, fb_addr SHALL be 0, fb_we 0.
REQ-020 Min latency: wr_req rise in IDLE -> wr_ack 1 cycle later (WRITE state); back-to-back accepts at most every 2 cycles.
REQ-021 Requester SHALL drop wr_req the cycle after wr_ack; wr_req still high in IDLE counts as a new request.
REQ-022 Full clear with vga_busy=0 throughout SHALL take exactly 600 write cycles plus 1 IDLE->CLEAR cycle.

Reset
REQ-023 reset=1 SHALL asynchronously force: state IDLE, clr_pending 0, counter 0, latched col/row/char/error 0; wr_ack, wr_err, clr_busy, clr_done, fb_we, fb_wdata 0; fb_addr per REQ-018/019.
REQ-024 Reset mid-WRITE or mid-CLEAR SHALL abandon the operation with no ack or done; the first post-reset cycle is IDLE.

Verification
REQ-025 vga_busy=0, wr_req col=3 row=2 char=8'h41 -> next cycle fb_we=1, fb_addr=83, fb_wdata=8'h41, wr_ack=1, wr_err=0.
REQ-026 wr_req col=40 row=0 -> wr_ack=1, wr_err=1, fb_we never 1.
REQ-027 clr_req, vga_busy=0 -> 600 consecutive writes of 8'h20 at addr 0..599, clr_done on addr 599, clr_busy low afterwards.
REQ-028 Valid write pending while vga_busy=1 for 10 cycles, vga_addr=10'd123 -> fb_addr=123, fb_we=0 those cycles; ack on first vga_busy=0 cycle.
REQ-029 clr_req and wr_req same cycle -> full clear completes first, then host write acked; second clr_req mid-sweep -> second full sweep after clr_done.
REQ-030 reset asserted at sweep address 300 -> outputs zero immediately, no clr_done; new clr_req restarts from address 0.
